// File: rtl/pe_operand_feeder_if.sv
// Host write/start port and PE-facing outputs of the column operand feeder.
// The master side belongs to the host/DMA; the slave side belongs to the feeder.
interface pe_operand_feeder_if #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 4,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic                   wr_en;
    logic                   wr_sel;
    logic [AW-1:0]          wr_addr;
    logic [ROWS*DATA_W-1:0] wr_data;
    logic [LW-1:0]          cfg_len;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   weight_en;
    logic [DATA_W-1:0]      weight_out;
    logic [ROWS*DATA_W-1:0] act_out;
    logic [ROWS-1:0]        act_valid;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, cfg_len, start,
        input  busy, done, weight_en, weight_out, act_out, act_valid
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, cfg_len, start,
        output busy, done, weight_en, weight_out, act_out, act_valid
    );
endinterface

// File: rtl/pe_operand_feeder.sv
// Feeds one systolic column: shifts the weight set in top-down, then streams
// buffered activation vectors with a one-cycle-per-row diagonal skew.
module pe_operand_feeder #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 4,
    parameter int DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pe_operand_feeder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(2 * ROWS + DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_FIN} state_t;

    state_t                 state_q;
    logic [CW-1:0]          t_q;
    logic [LW-1:0]          len_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   wen_q;
    logic [DATA_W-1:0]      wout_q;
    logic [ROWS*DATA_W-1:0] act_out_q;
    logic [ROWS-1:0]        act_valid_q;

    logic [ROWS*DATA_W-1:0] wbuf_q;
    logic [ROWS*DATA_W-1:0] act_mem [DEPTH];
    logic [ROWS*DATA_W-1:0] rdata_q;
    logic                   rvld_q;

    logic                   wr_ok;
    logic [ROWS*DATA_W-1:0] w_eff;
    logic [DATA_W-1:0]      w_elem [ROWS];
    logic [RW-1:0]          w_sel;
    logic [LW-1:0]          len_clamp;
    logic [CW-1:0]          stream_end;
    logic                   rd_issue;
    logic [AW-1:0]          rd_addr;
    logic [DATA_W-1:0]      row_data [ROWS];
    logic                   row_vld  [ROWS];

    // A weight write landing in the start cycle must already feed the first shift.
    assign wr_ok      = bus.wr_en && (state_q == S_IDLE);
    assign w_eff      = (wr_ok && !bus.wr_sel) ? bus.wr_data : wbuf_q;
    assign len_clamp  = (bus.cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.cfg_len;
    assign stream_end = CW'(2 * ROWS - 1) + CW'(len_q);
    assign w_sel      = (state_q == S_IDLE) ? RW'(ROWS - 1) : (RW'(ROWS - 1) - RW'(t_q));

    // Vector c is read two cycles before row 0 presents it (RAM stage + output stage).
    assign rd_issue = ((state_q == S_LOAD_W) || (state_q == S_STREAM)) &&
                      (t_q >= CW'(ROWS - 1)) &&
                      (t_q < CW'(ROWS - 1) + CW'(len_q));
    assign rd_addr  = AW'(t_q - CW'(ROWS - 1));

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_welem
            assign w_elem[gi] = w_eff[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
            wout_q  <= '0;
        end else begin
            done_q <= 1'b0;
            wen_q  <= 1'b0;
            wout_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q <= len_clamp;
                        t_q   <= CW'(1);
                        if (len_clamp == '0) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_LOAD_W;
                            busy_q  <= 1'b1;
                            wen_q   <= 1'b1;
                            wout_q  <= w_elem[w_sel];
                        end
                    end
                end
                S_LOAD_W: begin
                    t_q <= t_q + CW'(1);
                    if (t_q == CW'(ROWS)) begin
                        state_q <= S_STREAM;
                    end else begin
                        wen_q  <= 1'b1;
                        wout_q <= w_elem[w_sel];
                    end
                end
                S_STREAM: begin
                    t_q <= t_q + CW'(1);
                    if (t_q == stream_end) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    t_q     <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && bus.wr_sel) begin
            act_mem[bus.wr_addr] <= bus.wr_data;
        end
        rdata_q <= act_mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !bus.wr_sel) begin
            wbuf_q <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvld_q <= 1'b0;
        end else begin
            rvld_q <= rd_issue;
        end
    end

    // Row r sees the shared read word through r delay stages.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            if (gi == 0) begin : g_direct
                assign row_data[gi] = rdata_q[DATA_W-1:0];
                assign row_vld[gi]  = rvld_q;
            end else begin : g_delay
                logic [DATA_W-1:0] dd_q [gi];
                logic [gi-1:0]     dv_q;

                always_ff @(posedge clk) begin
                    dd_q[0] <= rdata_q[gi*DATA_W +: DATA_W];
                    for (int k = 1; k < gi; k++) begin
                        dd_q[k] <= dd_q[k-1];
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        dv_q <= '0;
                    end else begin
                        dv_q[0] <= rvld_q;
                        for (int k = 1; k < gi; k++) begin
                            dv_q[k] <= dv_q[k-1];
                        end
                    end
                end

                assign row_data[gi] = dd_q[gi-1];
                assign row_vld[gi]  = dv_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            act_out_q   <= '0;
            act_valid_q <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                act_valid_q[r]                <= row_vld[r];
                act_out_q[r*DATA_W +: DATA_W] <= row_vld[r] ? row_data[r] : '0;
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.weight_en  = wen_q;
    assign bus.weight_out = wout_q;
    assign bus.act_out    = act_out_q;
    assign bus.act_valid  = act_valid_q;
endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench for pe_operand_feeder (ROWS=4, DEPTH=16): a cycle table for a
// full L=3 run plus hand sequences for reset, ignored traffic, back-to-back and clamping.
module tb_pe_operand_feeder;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pe_operand_feeder_if #(.DATA_W(16), .ROWS(4), .DEPTH(16)) bus ();

    pe_operand_feeder #(.DATA_W(16), .ROWS(4), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [4:0]  len;
        logic        wr_en;
        logic        wr_sel;
        logic [3:0]  wr_addr;
        logic [63:0] wr_data;
        logic        busy;
        logic        done;
        logic        wen;
        logic [15:0] wout;
        logic [3:0]  av;
        logic [63:0] ao;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(logic st, logic [4:0] ln, logic we, logic ws,
                                logic [3:0] wa, logic [63:0] wd, logic b, logic d,
                                logic e, logic [15:0] wo, logic [3:0] av, logic [63:0] ao);
        vec_t v;
        v.start = st; v.len = ln; v.wr_en = we; v.wr_sel = ws; v.wr_addr = wa;
        v.wr_data = wd; v.busy = b; v.done = d; v.wen = e; v.wout = wo;
        v.av = av; v.ao = ao;
        return v;
    endfunction

    function automatic logic [86:0] obs();
        return {bus.busy, bus.done, bus.weight_en, bus.weight_out, bus.act_valid, bus.act_out};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.wr_en = 1'b0; bus.wr_sel = 1'b0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.cfg_len = '0;
    endtask

    task automatic wr(input logic sel, input logic [3:0] addr, input logic [63:0] data);
        bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_addr = addr; bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 14; i++) begin
            bus.start = tbl[i].start; bus.cfg_len = tbl[i].len;
            bus.wr_en = tbl[i].wr_en; bus.wr_sel = tbl[i].wr_sel;
            bus.wr_addr = tbl[i].wr_addr; bus.wr_data = tbl[i].wr_data;
            tick();
            idle_inputs();
            check($sformatf("%s_row%0d", tag, i), 128'(obs()),
                  128'({tbl[i].busy, tbl[i].done, tbl[i].wen, tbl[i].wout, tbl[i].av, tbl[i].ao}));
        end
    endtask

    // Counts done pulses over a fixed window; optionally injects start+write at cycle 2.
    task automatic run_count(input logic [4:0] len, input bit inject, output int lat, output int nd);
        lat = -1;
        nd  = 0;
        bus.start = 1'b1; bus.cfg_len = len;
        tick();
        bus.start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (bus.done) begin
                nd++;
                if (lat < 0) lat = n;
            end
            if (inject && n == 2) begin
                bus.start = 1'b1; bus.cfg_len = 5'd1;
                bus.wr_en = 1'b1; bus.wr_sel = 1'b1; bus.wr_addr = 4'd0;
                bus.wr_data = 64'hDEAD_DEAD_DEAD_DEAD;
            end
            tick();
            idle_inputs();
        end
    endtask

    int          lat;
    int          nd;
    logic [67:0] e_exp [4];

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        idle_inputs();

        tbl[0]  = mk(1, 5'd3, 0, 0, 0, 64'h0, 1, 0, 1, 16'h0200, 4'h0, 64'h0);
        tbl[1]  = mk(0, 5'd0, 0, 0, 0, 64'h0, 1, 0, 1, 16'hFC00, 4'h0, 64'h0);
        tbl[2]  = mk(0, 5'd0, 0, 0, 0, 64'h0, 1, 0, 1, 16'h0800, 4'h0, 64'h0);
        tbl[3]  = mk(1, 5'd0, 0, 0, 0, 64'h0, 1, 0, 1, 16'h0400, 4'h0, 64'h0);
        tbl[4]  = mk(0, 5'd0, 0, 0, 0, 64'h0, 1, 0, 0, 16'h0, 4'h1, 64'h0000_0000_0000_0001);
        tbl[5]  = mk(0, 5'd0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 16'h0, 4'h3, 64'h0000_0000_0002_0005);
        tbl[6]  = mk(0, 5'd0, 0, 0, 0, 64'h0, 1, 0, 0, 16'h0, 4'h7, 64'h0000_0003_0006_0009);
        tbl[7]  = mk(0, 5'd0, 0, 0, 0, 64'h0, 1, 0, 0, 16'h0, 4'hE, 64'h0004_0007_000A_0000);
        tbl[8]  = mk(0, 5'd0, 1, 0, 0, 64'h1111_1111_1111_1111, 1, 0, 0, 16'h0, 4'hC, 64'h0008_000B_0000_0000);
        tbl[9]  = mk(0, 5'd0, 0, 0, 0, 64'h0, 1, 0, 0, 16'h0, 4'h8, 64'h000C_0000_0000_0000);
        tbl[10] = mk(0, 5'd0, 0, 0, 0, 64'h0, 0, 1, 0, 16'h0, 4'h0, 64'h0);
        tbl[11] = mk(1, 5'd0, 0, 0, 0, 64'h0, 0, 0, 0, 16'h0, 4'h0, 64'h0);
        tbl[12] = mk(1, 5'd0, 0, 0, 0, 64'h0, 0, 1, 0, 16'h0, 4'h0, 64'h0);
        tbl[13] = mk(0, 5'd0, 0, 0, 0, 64'h0, 0, 0, 0, 16'h0, 4'h0, 64'h0);

        repeat (3) tick();
        check("reset_state", 128'(obs()), 128'(0));
        rst = 1'b0;
        tick();

        wr(1'b0, 4'd0, 64'h0200_FC00_0800_0400);
        wr(1'b1, 4'd0, 64'h0004_0003_0002_0001);
        wr(1'b1, 4'd1, 64'h0008_0007_0006_0005);
        wr(1'b1, 4'd2, 64'h000C_000B_000A_0009);
        run_table("run_l3");
        tick();

        // start and write while busy are dropped
        run_count(5'd2, 1'b1, lat, nd);
        check("busy_ignore_latency", 128'(lat), 128'(10));
        check("busy_ignore_done_count", 128'(nd), 128'(1));

        bus.start = 1'b1; bus.cfg_len = 5'd1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        check("buffer_unchanged_v0", 128'({bus.act_valid, bus.act_out}), 128'({4'h1, 64'h1}));
        repeat (4) tick();
        check("l1_done_latency", 128'(bus.done), 128'(1));
        tick();

        // reset mid-stream
        bus.start = 1'b1; bus.cfg_len = 5'd3;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrun_reset_outputs", 128'(obs()), 128'(0));
        nd = 0;
        repeat (2) begin tick(); nd += int'(bus.done); end
        rst = 1'b0;
        repeat (15) begin tick(); nd += int'(bus.done); end
        check("midrun_reset_no_done", 128'(nd), 128'(0));
        run_table("restart");
        tick();

        // same-cycle write and start: new v0 streamed
        e_exp[0] = {4'h1, 64'h0000_0000_0000_FFFF};
        e_exp[1] = {4'h2, 64'h0000_0000_1234_0000};
        e_exp[2] = {4'h4, 64'h0000_8000_0000_0000};
        e_exp[3] = {4'h8, 64'h7FFF_0000_0000_0000};
        bus.wr_en = 1'b1; bus.wr_sel = 1'b1; bus.wr_addr = 4'd0;
        bus.wr_data = 64'h7FFF_8000_1234_FFFF;
        bus.start = 1'b1; bus.cfg_len = 5'd1;
        tick();
        idle_inputs();
        for (int n = 1; n <= 9; n++) begin
            if (n >= 5 && n <= 8)
                check($sformatf("wr_start_n%0d", n), 128'({bus.act_valid, bus.act_out}), 128'(e_exp[n-5]));
            if (n == 9)
                check("wr_start_done", 128'(bus.done), 128'(1));
            if (n < 9) tick();
        end
        tick();

        // length clamp with a same-cycle weight write
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = 4'd0;
        bus.wr_data = 64'h0001_0002_0003_0004;
        bus.start = 1'b1; bus.cfg_len = 5'd31;
        tick();
        idle_inputs();
        check("wr_start_weight", 128'({bus.weight_en, bus.weight_out}), 128'({1'b1, 16'h0001}));
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (bus.done && lat < 0) lat = n;
            tick();
        end
        check("clamp_latency", 128'(lat), 128'(24));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
